// File: rtl/accu_pkg.sv
// Shared types and constants for the beat accumulator and the beat serializer (accu_split).
package accu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_BEATS  = 4;

  // Width that holds the sum of BEATS unsigned beats without overflow.
  function automatic int sum_w(input int data_w, input int beats);
    return data_w + $clog2(beats);
  endfunction

endpackage

// File: rtl/accu_split_sum.sv
// Combinational unsigned adder over the BEATS beats of one packed word.
module accu_split_sum
  import accu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BEATS  = DEF_BEATS,
  parameter int SUM_W  = sum_w(DATA_W, BEATS)
) (
  input  logic [BEATS*DATA_W-1:0] i_word,
  output logic [SUM_W-1:0]        o_sum
);

  always_comb begin
    o_sum = '0;
    for (int k = 0; k < BEATS; k++) begin
      o_sum = o_sum + SUM_W'(i_word[k*DATA_W +: DATA_W]);
    end
  end

endmodule

// File: rtl/accu_split.sv
// Beat serializer: one BEATS-byte word in, BEATS registered beats out, LSB beat first.
// Define ACCU_SPLIT_SUM_EN to add the registered sum_out port (byte sum of the accepted word).
module accu_split
  import accu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BEATS  = DEF_BEATS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BEATS*DATA_W-1:0] data_in,
  input  logic                    valid_a,
  output logic                    ready_a,
  input  logic                    ready_b,
  output logic                    valid_b,
  output logic [DATA_W-1:0]       data_out,
  output logic                    last_b
`ifdef ACCU_SPLIT_SUM_EN
  ,
  output logic [sum_w(DATA_W, BEATS)-1:0] sum_out
`endif
);

  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] PREV_CNT = CNT_W'(BEATS - 2);

  state_t                    r_state;
  logic [BEATS*DATA_W-1:0]   r_shift;
  logic [CNT_W-1:0]          r_cnt;
  logic [DATA_W-1:0]         r_data;
  logic                      r_valid;
  logic                      r_last;

  logic                      w_ready;
  logic                      w_accept;
  logic                      w_xfer;

  // A new word may enter while the final beat of the previous one leaves.
  assign w_ready  = rst_n & ((r_state == IDLE) |
                             ((r_state == SEND) & r_last & ready_b));
  assign w_accept = valid_a & w_ready;
  assign w_xfer   = r_valid & ready_b;

  assign ready_a  = w_ready;
  assign valid_b  = r_valid;
  assign data_out = r_data;
  assign last_b   = r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= SEND;
            r_shift <= data_in;
            r_data  <= data_in[DATA_W-1:0];
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
          end
        end
        SEND: begin
          if (w_xfer) begin
            if (r_cnt == LAST_CNT) begin
              if (w_accept) begin
                r_shift <= data_in;
                r_data  <= data_in[DATA_W-1:0];
                r_cnt   <= '0;
                r_valid <= 1'b1;
                r_last  <= 1'b0;
              end else begin
                // data_out keeps the final beat while idle.
                r_state <= IDLE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
              end
            end else begin
              r_shift <= r_shift >> DATA_W;
              r_data  <= r_shift[2*DATA_W-1:DATA_W];
              r_cnt   <= r_cnt + 1'b1;
              r_last  <= (r_cnt == PREV_CNT);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ACCU_SPLIT_SUM_EN
  localparam int SUM_W = sum_w(DATA_W, BEATS);

  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] r_sum;

  accu_split_sum #(
    .DATA_W (DATA_W),
    .BEATS  (BEATS),
    .SUM_W  (SUM_W)
  ) u_sum (
    .i_word (data_in),
    .o_sum  (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= w_sum;
    end
  end

  assign sum_out = r_sum;
`endif

endmodule

// File: tb/tb_accu_split.sv
// Self-checking bench for accu_split: directed scenarios plus a random loopback run against a queue model.
module tb_accu_split;

  localparam int DATA_W = 8;
  localparam int BEATS  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_in;
  logic        valid_a;
  logic        ready_a;
  logic        ready_b;
  logic        valid_b;
  logic [7:0]  data_out;
  logic        last_b;
`ifdef ACCU_SPLIT_SUM_EN
  logic [9:0]  sum_out;
`endif

  always #5 clk = ~clk;

  accu_split #(.DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .valid_a  (valid_a),
    .ready_a  (ready_a),
    .ready_b  (ready_b),
    .valid_b  (valid_b),
    .data_out (data_out),
    .last_b   (last_b)
`ifdef ACCU_SPLIT_SUM_EN
    ,
    .sum_out  (sum_out)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: remaining beats of the word in flight, LSB beat first.
  logic [7:0] q[$];
  logic [7:0] m_dout = 8'h00;
  logic [9:0] m_sum = 10'h000;
  int         m_acc_cnt = 0;
  int         sq[$];
  int         acc = 0;
  int         words_done = 0;
  logic [7:0] rx_log[$];
  logic [7:0] tmp;
  bit         acc_now;

  bit         s_xfer = 1'b0;
  bit         s_last = 1'b0;
  logic [7:0] s_d;
  logic [9:0] s_sum = 10'h000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit m_rdy();
    return (rst_n === 1'b1) && ((q.size() == 0) || ((q.size() == 1) && (ready_b === 1'b1)));
  endfunction

  function automatic int byte_sum(input logic [31:0] w);
    int s = 0;
    for (int k = 0; k < BEATS; k++) s += int'(w[k*8 +: 8]);
    return s;
  endfunction

  // Output checks and transfer sampling, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst_n !== 1'b1) begin
      chk("rst_valid_b", valid_b, 0);
      chk("rst_last_b", last_b, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_ready_a", ready_a, 0);
      s_xfer = 1'b0;
    end else begin
      chk("valid_b", valid_b, q.size() > 0);
      chk("last_b", last_b, q.size() == 1);
      chk("data_out", data_out, m_dout);
      chk("ready_a", ready_a, m_rdy());
`ifdef ACCU_SPLIT_SUM_EN
      chk("sum_out", sum_out, m_sum);
      s_sum = sum_out;
`endif
      s_xfer = (valid_b === 1'b1) && (ready_b === 1'b1);
      s_d    = data_out;
      s_last = last_b;
    end
  end

  // Model update at the active edge, from bench-driven inputs only.
  initial forever begin
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      q.delete();
      sq.delete();
      m_dout = 8'h00;
      m_sum  = 10'h000;
      acc    = 0;
    end else begin
      acc_now = (valid_a === 1'b1) && m_rdy();
      if (s_xfer) begin
        rx_log.push_back(s_d);
        acc += int'(s_d);
        if (s_last) begin
          if (sq.size() > 0) chk("word_sum", acc, sq.pop_front());
          else chk("word_sum_unexpected", acc, 32'hFFFF_FFFF);
`ifdef ACCU_SPLIT_SUM_EN
          chk("sum_vs_accum", s_sum, acc);
`endif
          acc = 0;
          words_done++;
        end
      end
      if ((q.size() > 0) && (ready_b === 1'b1)) tmp = q.pop_front();
      if (acc_now) begin
        for (int k = 0; k < BEATS; k++) q.push_back(data_in[k*8 +: 8]);
        m_sum = 10'(byte_sum(data_in));
        sq.push_back(byte_sum(data_in));
        m_acc_cnt++;
      end
      if (q.size() > 0) m_dout = q[0];
    end
  end

  task automatic send_word(input logic [31:0] w);
    int c;
    bit ok;
    c  = m_acc_cnt;
    ok = 1'b0;
    valid_a = 1'b1;
    data_in = w;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (m_acc_cnt != c) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_seen", ok, 1);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("drain_done", ok, 1);
  endtask

  task automatic chk_log(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_len"}, rx_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_log.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), rx_log[i], exp[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp[$];
    int prev;
    int sent;
    int wd0;

    rst_n   = 1'b0;
    valid_a = 1'b0;
    ready_b = 1'b0;
    data_in = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word, free-flowing sink.
    ready_b = 1'b1;
    rx_log.delete();
    send_word(32'h0403_0201);
    valid_a = 1'b0;
    drain();
    exp = '{8'h01, 8'h02, 8'h03, 8'h04};
    chk_log("t1", exp);
`ifdef ACCU_SPLIT_SUM_EN
    chk("t1_sum", sum_out, 10'd10);
`endif

    // Back-to-back words without a bubble.
    rx_log.delete();
    send_word(32'hFFFF_FFFF);
`ifdef ACCU_SPLIT_SUM_EN
    chk("t2_sum_a", sum_out, 10'h3FC);
`endif
    send_word(32'h0000_0080);
    valid_a = 1'b0;
`ifdef ACCU_SPLIT_SUM_EN
    chk("t2_sum_b", sum_out, 10'h080);
`endif
    drain();
    exp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h00};
    chk_log("t2", exp);

    // Backpressure on beat 2.
    rx_log.delete();
    send_word(32'hA1B2_C3D4);
    valid_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ready_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t3_hold_data", data_out, 8'hB2);
      chk("t3_hold_valid", valid_b, 1);
      chk("t3_ready_a", ready_a, 0);
    end
    ready_b = 1'b1;
    drain();
    exp = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    chk_log("t3", exp);

    // Idle gap, then a fresh word.
    rx_log.delete();
    send_word(32'hDEAD_BEEF);
    valid_a = 1'b0;
    drain();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_idle_valid", valid_b, 0);
      chk("t4_idle_last", last_b, 0);
    end
    send_word(32'h1122_3344);
    valid_a = 1'b0;
    chk("t4_first_beat", data_out, 8'h44);
    drain();
    exp = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h44, 8'h33, 8'h22, 8'h11};
    chk_log("t4", exp);

    // Reset in the middle of a word.
    rx_log.delete();
    send_word(32'h0A0B_0C0D);
    valid_a = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", valid_b, 0);
    chk("t5_async_ready", ready_a, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    exp = '{8'h0D};
    chk_log("t5_partial", exp);
    rx_log.delete();
    send_word(32'h5566_7788);
    valid_a = 1'b0;
    chk("t5_restart_beat", data_out, 8'h88);
    drain();
    exp = '{8'h88, 8'h77, 8'h66, 8'h55};
    chk_log("t5_next", exp);

    // Random words, random sink stalls and upstream gaps.
    wd0  = words_done;
    prev = m_acc_cnt;
    sent = 0;
    valid_a = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      if (m_acc_cnt != prev) begin
        prev = m_acc_cnt;
        sent++;
        valid_a = 1'b0;
      end
      ready_b = ($urandom_range(0, 3) != 0);
      if (!valid_a) begin
        data_in = $urandom;
        if ((sent < 100) && ($urandom_range(0, 2) != 0)) valid_a = 1'b1;
      end
      if ((sent >= 100) && (q.size() == 0)) break;
    end
    valid_a = 1'b0;
    ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rand_words", words_done - wd0, 100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
